unified_mem_arbiter: RTL and testbench

Sequencing arbiter that shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline. Each pipeline step needs at most one data access and one fetch. The arbiter serialises them, data first, and freezes the pipeline until both are complete. It then releases the pipeline for exactly one cycle, driving the PC-write, IF/ID-write and pipeline-enable controls.

---
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Sequencing arbiter sharing one single-port memory between instruction
// fetch and the MEM stage. A pipeline step performs the data access first,
// then the fetch, then releases the pipeline for exactly one ADV cycle.
//
// Memory handshake: mem_req is a valid that stays high, with mem_we,
// mem_addr and mem_wdata stable, until the memory answers with mem_ack
// (acting as ready/complete). The access completes on the rising edge where
// mem_req and mem_ack are both 1; mem_rdata is sampled on that same edge.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  dm_read,
  input  logic                  dm_write,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  pipe_en,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    FETCH = 3'd2,
    ADV   = 3'd3,
    ERR   = 3'd4
  } arbStateT;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  arbStateT              state;
  arbStateT              nextState;
  logic [7:0]            waitCnt;
  logic                  waitHit;
  logic                  latWe;
  logic                  latFetch;
  logic [ADDR_WIDTH-1:0] latDAddr;
  logic [DATA_WIDTH-1:0] latDWdata;
  logic [ADDR_WIDTH-1:0] latIAddr;

  // The access times out when this un-acked cycle would bring the count to
  // MAX_WAIT; an ack in that very cycle takes priority.
  assign waitHit = ((waitCnt + 8'd1) == MaxWaitC) && !mem_ack;

  // Next-state decode: data before fetch, one ADV cycle, ERR is terminal.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (dm_read || dm_write) nextState = DATA;
        else if (if_req)         nextState = FETCH;
      end
      DATA: begin
        if (mem_ack)      nextState = latFetch ? FETCH : ADV;
        else if (waitHit) nextState = ERR;
      end
      FETCH: begin
        if (mem_ack)      nextState = ADV;
        else if (waitHit) nextState = ERR;
      end
      ADV:     nextState = IDLE;
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
  end

  // State register and watchdog counter; the counter only runs while waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= 8'd0;
    end else begin
      state <= nextState;
      if ((state == DATA || state == FETCH) && !mem_ack) waitCnt <= waitCnt + 8'd1;
      else                                               waitCnt <= 8'd0;
    end
  end

  // Snapshot the step's requests in IDLE so memory outputs come from flops only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latWe     <= 1'b0;
      latFetch  <= 1'b0;
      latDAddr  <= '0;
      latDWdata <= '0;
      latIAddr  <= '0;
    end else if (state == IDLE) begin
      latWe     <= dm_write;
      latFetch  <= if_req;
      latDAddr  <= dm_addr;
      latDWdata <= dm_wdata;
      latIAddr  <= if_addr;
    end
  end

  // Capture read data on ack: loads into dm_rdata, fetches into instr_out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_out <= '0;
      dm_rdata  <= '0;
    end else if (mem_ack) begin
      if (state == DATA && !latWe) dm_rdata  <= mem_rdata;
      if (state == FETCH)          instr_out <= mem_rdata;
    end
  end

  // Sticky fault: simultaneous load+store request or watchdog expiry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      if (state == IDLE && dm_read && dm_write)          err <= 1'b1;
      if ((state == DATA || state == FETCH) && waitHit) err <= 1'b1;
    end
  end

  assign busy        = (state == DATA) || (state == FETCH);
  assign mem_req     = busy;
  assign mem_we      = (state == DATA) && latWe;
  assign mem_addr    = (state == DATA)  ? latDAddr :
                       (state == FETCH) ? latIAddr : '0;
  assign mem_wdata   = (state == DATA)  ? latDWdata : '0;
  assign pc_write    = (state == ADV);
  assign if_id_write = (state == ADV);
  assign pipe_en     = (state == ADV);
  assign dbgState    = state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed + randomized bench for unified_mem_arbiter. The bench plays the
// memory: for every pipeline step it derives the ordered list of accesses
// and the expected captured values from the arbitration rules, then walks
// the DUT cycle by cycle against that list.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] dm_rdata;
  logic          pc_write;
  logic          if_id_write;
  logic          pipe_en;
  logic          busy;
  logic          err;
  logic [2:0]    dbgState;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr_out(instr_out), .dm_rdata(dm_rdata),
    .pc_write(pc_write), .if_id_write(if_id_write), .pipe_en(pipe_en),
    .busy(busy), .err(err), .dbgState(dbgState)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: what the pipeline should see after each step.
  logic [DW-1:0] expInstr;
  logic [DW-1:0] expDm;
  logic          expErr;

  // Scoreboard of expected memory accesses for the current step.
  logic [AW-1:0] exp_q[$];
  logic          expWe_q[$];
  logic          expData_q[$];
  logic [DW-1:0] expWd_q[$];
  logic [DW-1:0] rdat_q[$];
  int            lat_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    check1({tag, "_req"}, mem_req, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_pcw"}, pc_write, 1'b0);
    check1({tag, "_ifid"}, if_id_write, 1'b0);
    check1({tag, "_pen"}, pipe_en, 1'b0);
    check1({tag, "_we"}, mem_we, 1'b0);
    check32({tag, "_addr"}, mem_addr, 32'h0);
  endtask

  // One pipeline step; entered and left at a negedge with the DUT in IDLE.
  task automatic runStep(input string tag, input logic rd, input logic wr, input logic fe,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input logic [31:0] rdD, input logic [31:0] rdF,
                         input int kd, input int kf);
    checkQuiet({tag, "_idle"});
    if_req = fe; if_addr = ia; dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = wd;
    exp_q.delete(); expWe_q.delete(); expData_q.delete(); expWd_q.delete();
    rdat_q.delete(); lat_q.delete();
    if (rd || wr) begin
      exp_q.push_back(da); expWe_q.push_back(wr); expData_q.push_back(1'b1);
      expWd_q.push_back(wd); rdat_q.push_back(rdD); lat_q.push_back(kd);
      if (!wr) expDm = rdD;
      if (rd && wr) expErr = 1'b1;
    end
    if (fe) begin
      exp_q.push_back(ia); expWe_q.push_back(1'b0); expData_q.push_back(1'b0);
      expWd_q.push_back(32'h0); rdat_q.push_back(rdF); lat_q.push_back(kf);
      expInstr = rdF;
    end
    if (exp_q.size() == 0) begin
      nextCycle();
      checkQuiet({tag, "_noreq"});
      return;
    end
    while (exp_q.size() != 0) begin
      logic [AW-1:0] a;
      logic          w;
      logic          isD;
      logic [DW-1:0] d;
      logic [DW-1:0] r;
      int            k;
      a = exp_q.pop_front(); w = expWe_q.pop_front(); isD = expData_q.pop_front();
      d = expWd_q.pop_front(); r = rdat_q.pop_front(); k = lat_q.pop_front();
      for (int c = 1; c <= k; c++) begin
        nextCycle();
        mem_ack = 1'b0;
        check1({tag, "_req"}, mem_req, 1'b1);
        check1({tag, "_busy"}, busy, 1'b1);
        check32({tag, "_addr"}, mem_addr, a);
        check1({tag, "_we"}, mem_we, w);
        if (isD) check32({tag, "_wdata"}, mem_wdata, d);
        check1({tag, "_pcw_busy"}, pc_write, 1'b0);
        if (c == k) begin
          mem_ack = 1'b1;
          mem_rdata = r;
        end else begin
          mem_rdata = 32'($urandom);
        end
      end
    end
    nextCycle();
    mem_ack = 1'b0;
    check1({tag, "_pcw"}, pc_write, 1'b1);
    check1({tag, "_ifid"}, if_id_write, 1'b1);
    check1({tag, "_pen"}, pipe_en, 1'b1);
    check1({tag, "_adv_req"}, mem_req, 1'b0);
    check32({tag, "_instr"}, instr_out, expInstr);
    check32({tag, "_dmr"}, dm_rdata, expDm);
    check1({tag, "_err"}, err, expErr);
    nextCycle();
  endtask

  task automatic applyReset();
    reset = 1'b0;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b0;
    repeat (2) nextCycle();
    expInstr = '0; expDm = '0; expErr = 1'b0;
    checkQuiet("rst");
    check32("rst_instr", instr_out, 32'h0);
    check32("rst_dmr", dm_rdata, 32'h0);
    check32("rst_wdata", mem_wdata, 32'h0);
    check1("rst_err", err, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    @(negedge clk);
    applyReset();

    // Fetch only, ack in first cycle: ADV every third cycle.
    repeat (3) runStep("fetch", 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 32'h0, 32'h20080005, 1, 1);
    // Load with latency 3, then fetch.
    runStep("ldfe", 1'b1, 1'b0, 1'b1, 32'h8, 32'h40, 32'h0, 32'hDEADBEEF, 32'h8C090000, 3, 1);
    // Store only: dm_rdata must keep the load value.
    runStep("store", 1'b0, 1'b1, 1'b0, 32'hC, 32'h44, 32'h12345678, 32'hFFFFFFFF, 32'h0, 2, 1);
    // Acks landing exactly on the watchdog limit win.
    runStep("edge", 1'b1, 1'b0, 1'b1, 32'h10, 32'h80, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, MW, MW);
    runStep("none", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      logic rd, wr, fe;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'b0 : 1'($urandom_range(0, 1));
      fe = 1'($urandom_range(0, 1));
      runStep("rand", rd, wr, fe, 32'($urandom), 32'($urandom), 32'($urandom),
              32'($urandom), 32'($urandom), int'($urandom_range(1, MW)), int'($urandom_range(1, MW)));
    end

    // Illegal load+store: performed as a store, err set and sticky.
    runStep("illegal", 1'b1, 1'b1, 1'b1, 32'h14, 32'h48, 32'hCAFEF00D, 32'h11111111, 32'h22222222, 1, 2);
    runStep("sticky", 1'b0, 1'b0, 1'b1, 32'h18, 32'h0, 32'h0, 32'h0, 32'h33333333, 1, 1);

    // Reset during FETCH, then a stale ack in IDLE.
    if_req = 1'b1; if_addr = 32'h1C;
    nextCycle();
    check1("midrst_req", mem_req, 1'b1);
    reset = 1'b0;
    nextCycle();
    check1("midrst_drop", mem_req, 1'b0);
    check1("midrst_err", err, 1'b0);
    check32("midrst_instr", instr_out, 32'h0);
    reset = 1'b1; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    expInstr = '0; expDm = '0; expErr = 1'b0;
    repeat (3) begin
      nextCycle();
      checkQuiet("stale");
      check32("stale_instr", instr_out, 32'h0);
    end
    mem_ack = 1'b0;
    runStep("postrst", 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 32'h0, 32'h01234567, 1, 1);

    // Watchdog: no ack for MAX_WAIT data cycles.
    dm_read = 1'b1; dm_addr = 32'h50; if_req = 1'b1;
    for (int c = 0; c < MW; c++) begin
      nextCycle();
      check1("wd_req", mem_req, 1'b1);
      check1("wd_err_early", err, 1'b0);
    end
    nextCycle();
    check1("wd_err", err, 1'b1);
    check1("wd_req_drop", mem_req, 1'b0);
    check1("wd_busy", busy, 1'b0);
    repeat (6) begin
      mem_ack = 1'($urandom_range(0, 1));
      nextCycle();
      check1("wd_hold_pcw", pc_write, 1'b0);
      check1("wd_hold_req", mem_req, 1'b0);
      check1("wd_hold_err", err, 1'b1);
    end
    applyReset();
    runStep("final", 1'b0, 1'b0, 1'b1, 32'h24, 32'h0, 32'h0, 32'h0, 32'h76543210, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
